bmp280_frame_asm: RTL and testbench

- Assembles the raw BMP280 register byte stream from the upstream I2C byte reader into the calibration words, ADC words and completion flag that feed the soft-processor subsystem's PIO inputs (dig_t1..dig_p9, adc_t, adc_p, end_o).
- Handles two burst types: the 24-byte calibration burst from register 0x88 and the 6-byte measurement burst from register 0xF7.
- Commits each burst to its outputs atomically, so firmware never reads a torn value.

---
 rtl/bmp280_frame_asm.sv | 128 ++++++++++++
 tb/tb_bmp280_frame_asm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bmp280_frame_asm.sv
// BMP280 burst assembler: collects calibration (0x88, 24 B) and measurement (0xF7, 6 B)
// register bursts in a shadow buffer and commits them to the PIO outputs on a single edge.
module bmp280_frame_asm #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int TO_W           = 13
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        frame_start,
    input  logic        frame_type,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [15:0] dig_t1_export,
    output logic [15:0] dig_t2_export,
    output logic [15:0] dig_t3_export,
    output logic [15:0] dig_p1_export,
    output logic [15:0] dig_p2_export,
    output logic [15:0] dig_p3_export,
    output logic [15:0] dig_p4_export,
    output logic [15:0] dig_p5_export,
    output logic [15:0] dig_p6_export,
    output logic [15:0] dig_p7_export,
    output logic [15:0] dig_p8_export,
    output logic [15:0] dig_p9_export,
    output logic [23:0] adc_t_export,
    output logic [23:0] adc_p_export,
    output logic        end_o_export,
    output logic        cal_valid,
    output logic        frame_err,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAL  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [4:0]        idx_q;
    logic [TO_W-1:0]   to_q;
    logic [7:0]        shadow_q [24];
    logic [15:0]       dig_q [12];
    logic [23:0]       adc_t_q;
    logic [23:0]       adc_p_q;
    logic              end_q;
    logic              cal_valid_q;
    logic              err_q;

    logic [TO_W-1:0]   to_d;
    logic [4:0]        last_idx_d;

    always_comb begin
        to_d       = to_q + 1'b1;
        last_idx_d = (state_q == ST_MEAS) ? 5'd5 : 5'd23;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 5'd0;
            to_q        <= '0;
            adc_t_q     <= 24'd0;
            adc_p_q     <= 24'd0;
            end_q       <= 1'b0;
            cal_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < 12; k++) dig_q[k] <= 16'd0;
        end else begin
            err_q <= 1'b0;
            // A new burst always wins, including over a coincident final byte.
            if (frame_start) begin
                if (state_q != ST_IDLE) err_q <= 1'b1;
                state_q <= frame_type ? ST_MEAS : ST_CAL;
                idx_q   <= 5'd0;
                to_q    <= '0;
                if (frame_type) end_q <= 1'b0;
            end else if (state_q == ST_IDLE) begin
                if (byte_valid) err_q <= 1'b1;
            end else if (byte_valid) begin
                shadow_q[idx_q] <= byte_data;
                idx_q           <= idx_q + 5'd1;
                to_q            <= '0;
                if (idx_q == last_idx_d) begin
                    state_q <= ST_IDLE;
                    if (state_q == ST_CAL) begin
                        for (int k = 0; k < 11; k++)
                            dig_q[k] <= {shadow_q[2*k+1], shadow_q[2*k]};
                        dig_q[11]   <= {byte_data, shadow_q[22]};
                        cal_valid_q <= 1'b1;
                    end else begin
                        adc_p_q <= {4'h0, shadow_q[0], shadow_q[1], shadow_q[2][7:4]};
                        adc_t_q <= {4'h0, shadow_q[3], shadow_q[4], byte_data[7:4]};
                        end_q   <= 1'b1;
                    end
                end
            end else if (to_q == TO_LAST) begin
                state_q <= ST_IDLE;
                to_q    <= '0;
                err_q   <= 1'b1;
            end else begin
                to_q <= to_d;
            end
        end
    end

    assign dig_t1_export = dig_q[0];
    assign dig_t2_export = dig_q[1];
    assign dig_t3_export = dig_q[2];
    assign dig_p1_export = dig_q[3];
    assign dig_p2_export = dig_q[4];
    assign dig_p3_export = dig_q[5];
    assign dig_p4_export = dig_q[6];
    assign dig_p5_export = dig_q[7];
    assign dig_p6_export = dig_q[8];
    assign dig_p7_export = dig_q[9];
    assign dig_p8_export = dig_q[10];
    assign dig_p9_export = dig_q[11];
    assign adc_t_export  = adc_t_q;
    assign adc_p_export  = adc_p_q;
    assign end_o_export  = end_q;
    assign cal_valid     = cal_valid_q;
    assign frame_err     = err_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_bmp280_frame_asm.sv
// Bench for bmp280_frame_asm: directed scenarios plus random bursts against a
// burst-level reference model (byte queue per burst, words computed on completion).
module tb_bmp280_frame_asm;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fs = 1'b0, ft = 1'b0, bv = 1'b0;
    logic [7:0]  bd = 8'h00;
    logic [15:0] dig_w [12];
    logic [23:0] adc_t, adc_p;
    logic        end_o, cal_v, ferr;
    logic [1:0]  st_dbg;

    bmp280_frame_asm #(.TIMEOUT_CYCLES(TO), .TO_W(6)) dut (
        .clk_clk(clk), .reset_reset(rst), .frame_start(fs), .frame_type(ft),
        .byte_valid(bv), .byte_data(bd),
        .dig_t1_export(dig_w[0]), .dig_t2_export(dig_w[1]), .dig_t3_export(dig_w[2]),
        .dig_p1_export(dig_w[3]), .dig_p2_export(dig_w[4]), .dig_p3_export(dig_w[5]),
        .dig_p4_export(dig_w[6]), .dig_p5_export(dig_w[7]), .dig_p6_export(dig_w[8]),
        .dig_p7_export(dig_w[9]), .dig_p8_export(dig_w[10]), .dig_p9_export(dig_w[11]),
        .adc_t_export(adc_t), .adc_p_export(adc_p), .end_o_export(end_o),
        .cal_valid(cal_v), .frame_err(ferr), .state_dbg_o(st_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0]  burst_q[$];
    bit          m_active = 0;
    bit          m_kind = 0;
    int          m_idle = 0;
    logic [15:0] exp_dig [12];
    logic [23:0] exp_adc_t = 0, exp_adc_p = 0;
    bit          exp_end = 0, exp_cal = 0, exp_err = 0;
    int          exp_err_cnt = 0;
    int          err_seen = 0;

    task automatic model_step(input bit r, input bit s, input bit t, input bit v, input logic [7:0] d);
        exp_err = 0;
        if (r) begin
            m_active = 0; burst_q.delete();
            for (int k = 0; k < 12; k++) exp_dig[k] = 0;
            exp_adc_t = 0; exp_adc_p = 0; exp_end = 0; exp_cal = 0;
        end else if (s) begin
            if (m_active) exp_err = 1;
            m_active = 1; m_kind = t; m_idle = 0; burst_q.delete();
            if (t) exp_end = 0;
        end else if (v) begin
            if (!m_active) exp_err = 1;
            else begin
                burst_q.push_back(d);
                m_idle = 0;
                if (burst_q.size() == (m_kind ? 6 : 24)) begin
                    if (!m_kind) begin
                        for (int k = 0; k < 12; k++) exp_dig[k] = {burst_q[2*k+1], burst_q[2*k]};
                        exp_cal = 1;
                    end else begin
                        exp_adc_p = (24'(burst_q[0]) << 12) + (24'(burst_q[1]) << 4) + 24'(burst_q[2] >> 4);
                        exp_adc_t = (24'(burst_q[3]) << 12) + (24'(burst_q[4]) << 4) + 24'(burst_q[5] >> 4);
                        exp_end = 1;
                    end
                    m_active = 0;
                end
            end
        end else if (m_active) begin
            m_idle++;
            if (m_idle == TO) begin exp_err = 1; m_active = 0; end
        end
        if (exp_err) exp_err_cnt++;
    endtask

    // One clock: drive inputs, update the model, sample outputs 1 time unit after the edge.
    task automatic cycle(input bit r, input bit s, input bit t, input bit v, input logic [7:0] d);
        rst = r; fs = s; ft = t; bv = v; bd = d;
        @(posedge clk);
        #1;
        model_step(r, s, t, v, d);
        if (ferr) err_seen++;
        rst = 0; fs = 0; ft = 0; bv = 0; bd = 8'h00;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        err_seen = 0; exp_err_cnt = 0;
        total++; if (st_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st_dbg); end
        total++; if ({end_o, cal_v, ferr} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {end_o, cal_v, ferr}); end
        for (int k = 0; k < 12; k++) begin
            total++; if (dig_w[k] !== 16'h0) begin bad++; $display("FAIL reset_dig%0d got=%h want=0", k, dig_w[k]); end
        end
        total++; if ({adc_t, adc_p} !== 48'h0) begin bad++; $display("FAIL reset_adc got=%h want=0", {adc_t, adc_p}); end
    endtask

    task automatic test_cal_seq();
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 23; i++) cycle(0, 0, 0, 1, 8'(i));
        total++; if (dig_w[0] !== 16'h0000) begin bad++; $display("FAIL cal_early got=%h want=0000", dig_w[0]); end
        cycle(0, 0, 0, 1, 8'h17);
        total++; if (dig_w[0] !== 16'h0100) begin bad++; $display("FAIL cal_t1 got=%h want=0100", dig_w[0]); end
        total++; if (dig_w[1] !== 16'h0302) begin bad++; $display("FAIL cal_t2 got=%h want=0302", dig_w[1]); end
        total++; if (dig_w[11] !== 16'h1716) begin bad++; $display("FAIL cal_p9 got=%h want=1716", dig_w[11]); end
        for (int k = 0; k < 12; k++) begin
            total++; if (dig_w[k] !== exp_dig[k]) begin bad++; $display("FAIL cal_dig%0d got=%h want=%h", k, dig_w[k], exp_dig[k]); end
        end
        total++; if ({cal_v, end_o} !== 2'b10) begin bad++; $display("FAIL cal_flags got=%b want=10", {cal_v, end_o}); end
        total++; if (err_seen !== 0) begin bad++; $display("FAIL cal_noerr got=%0d want=0", err_seen); end
    endtask

    task automatic test_meas_fixed();
        logic [7:0] b [6];
        b[0] = 8'h65; b[1] = 8'h5A; b[2] = 8'hC0; b[3] = 8'h7E; b[4] = 8'hED; b[5] = 8'h00;
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, b[i]);
        total++; if (adc_p !== 24'h0655AC) begin bad++; $display("FAIL meas_adc_p got=%h want=0655ac", adc_p); end
        total++; if (adc_t !== 24'h07EED0) begin bad++; $display("FAIL meas_adc_t got=%h want=07eed0", adc_t); end
        total++; if (end_o !== 1'b1) begin bad++; $display("FAIL meas_end got=%b want=1", end_o); end
        cycle(0, 1, 1, 0, 0);
        total++; if (end_o !== 1'b0) begin bad++; $display("FAIL meas_end_clear got=%b want=0", end_o); end
    endtask

    // Continues the MEAS burst opened by test_meas_fixed.
    task automatic test_timeout();
        int e0;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        e0 = err_seen;
        for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0, 0);
        total++; if (err_seen !== e0 || st_dbg !== 2'd2) begin bad++; $display("FAIL to_early err=%0d st=%0d want err=%0d st=2", err_seen, st_dbg, e0); end
        cycle(0, 0, 0, 0, 0);
        total++; if (ferr !== 1'b1) begin bad++; $display("FAIL to_pulse got=%b want=1", ferr); end
        total++; if (st_dbg !== 2'd0) begin bad++; $display("FAIL to_state got=%0d want=0", st_dbg); end
        total++; if (adc_p !== 24'h0655AC || adc_t !== 24'h07EED0) begin bad++; $display("FAIL to_hold got=%h/%h want=0655ac/07eed0", adc_p, adc_t); end
        total++; if (end_o !== 1'b0) begin bad++; $display("FAIL to_end got=%b want=0", end_o); end
        cycle(0, 0, 0, 0, 0);
        total++; if (ferr !== 1'b0) begin bad++; $display("FAIL to_one_cycle got=%b want=0", ferr); end
    endtask

    task automatic test_restart();
        int e0;
        e0 = err_seen;
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        cycle(0, 1, 0, 1, 8'h5C);
        for (int i = 0; i < 24; i++) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        total++; if (err_seen - e0 !== 1) begin bad++; $display("FAIL restart_err got=%0d want=1", err_seen - e0); end
        for (int k = 0; k < 12; k++) begin
            total++; if (dig_w[k] !== exp_dig[k]) begin bad++; $display("FAIL restart_dig%0d got=%h want=%h", k, dig_w[k], exp_dig[k]); end
        end
    endtask

    task automatic test_idle_byte();
        logic [23:0] p0;
        p0 = adc_p;
        cycle(0, 0, 0, 1, 8'hAA);
        total++; if (ferr !== 1'b1) begin bad++; $display("FAIL idle_err got=%b want=1", ferr); end
        total++; if (adc_p !== p0 || st_dbg !== 2'd0) begin bad++; $display("FAIL idle_hold adc_p=%h st=%0d want %h/0", adc_p, st_dbg, p0); end
        cycle(0, 1, 1, 1, 8'h11);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        total++; if (end_o !== 1'b0 || st_dbg !== 2'd2) begin bad++; $display("FAIL start_byte_counted end=%b st=%0d want 0/2", end_o, st_dbg); end
        cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        total++; if (end_o !== 1'b1 || adc_p !== exp_adc_p || adc_t !== exp_adc_t) begin bad++; $display("FAIL start_byte_commit end=%b p=%h t=%h want 1/%h/%h", end_o, adc_p, adc_t, exp_adc_p, exp_adc_t); end
    endtask

    task automatic test_final_collision();
        logic [23:0] p0;
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        p0 = adc_p;
        cycle(0, 1, 0, 1, 8'hF0);
        total++; if (ferr !== 1'b1 || end_o !== 1'b0 || adc_p !== p0) begin bad++; $display("FAIL collide err=%b end=%b p=%h want 1/0/%h", ferr, end_o, adc_p, p0); end
        total++; if (st_dbg !== 2'd1) begin bad++; $display("FAIL collide_state got=%0d want=1", st_dbg); end
        for (int i = 0; i < 24; i++) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        total++; if (dig_w[5] !== exp_dig[5]) begin bad++; $display("FAIL collide_cal got=%h want=%h", dig_w[5], exp_dig[5]); end
    endtask

    task automatic test_reset_mid();
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        cycle(1, 0, 0, 1, 8'h33);
        total++; if ({adc_t, adc_p, end_o, cal_v, ferr} !== 51'h0 || dig_w[0] !== 16'h0 || st_dbg !== 2'd0) begin bad++; $display("FAIL rst_mid adc=%h/%h flags=%b%b%b dig0=%h st=%0d want all 0", adc_t, adc_p, end_o, cal_v, ferr, dig_w[0], st_dbg); end
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
        total++; if (adc_p !== exp_adc_p || adc_t !== exp_adc_t || end_o !== 1'b1) begin bad++; $display("FAIL rst_mid_after p=%h t=%h e=%b want %h/%h/1", adc_p, adc_t, end_o, exp_adc_p, exp_adc_t); end
    endtask

    task automatic test_random();
        bit t;
        int n;
        for (int b = 0; b < 20; b++) begin
            if ($urandom_range(0, 4) == 0) cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
            t = 1'($urandom_range(0, 1));
            n = t ? 6 : 24;
            cycle(0, 1, t, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 3)) cycle(0, 0, 0, 0, 0);
                cycle(0, 0, 0, 1, 8'($urandom_range(0, 255)));
            end
            for (int k = 0; k < 12; k++) begin
                total++; if (dig_w[k] !== exp_dig[k]) begin bad++; $display("FAIL rnd%0d_dig%0d got=%h want=%h", b, k, dig_w[k], exp_dig[k]); end
            end
            total++; if (adc_p !== exp_adc_p || adc_t !== exp_adc_t) begin bad++; $display("FAIL rnd%0d_adc got=%h/%h want=%h/%h", b, adc_p, adc_t, exp_adc_p, exp_adc_t); end
            total++; if (end_o !== exp_end || cal_v !== exp_cal) begin bad++; $display("FAIL rnd%0d_flags got=%b%b want=%b%b", b, end_o, cal_v, exp_end, exp_cal); end
            total++; if (err_seen !== exp_err_cnt) begin bad++; $display("FAIL rnd%0d_errcnt got=%0d want=%0d", b, err_seen, exp_err_cnt); end
        end
    endtask

    initial begin
        for (int k = 0; k < 12; k++) exp_dig[k] = 0;
        test_reset();
        test_cal_seq();
        test_meas_fixed();
        test_timeout();
        test_restart();
        test_idle_byte();
        test_final_collision();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
